// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch unit with a DEPTH-entry queue of
//               {pc, instruction} pairs feeding the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     imemREN,
    output logic [31:0]              imemaddr,
    input  logic                     ihit,
    input  logic [31:0]              imemload,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_instr,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_npc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int                c_PTR_W  = $clog2(DEPTH);
    localparam int                c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FULL   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:0]         r_mem_pc    [DEPTH];
    logic [31:0]         r_mem_instr [DEPTH];
    logic                w_enq;
    logic                w_deq;
    logic                w_unused;

    // Word alignment discards the low bits of the restart address.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign imemREN   = (r_state == S_RUN) && !halt && !redirect;
    assign imemaddr  = r_fetch_pc;
    assign w_enq     = imemREN && ihit;
    assign w_deq     = deq_valid && deq_ready && !redirect;

    assign deq_valid = (r_count != '0);
    assign deq_pc    = r_mem_pc[r_head];
    assign deq_instr = r_mem_instr[r_head];
    assign deq_npc   = r_mem_pc[r_head] + 32'd4;
    assign count     = r_count;
    assign halted    = (r_state == S_HALTED);

    always_comb begin
        w_state_nxt = r_state;
        if (halt || (r_state == S_HALTED)) begin
            w_state_nxt = S_HALTED;
        end else if (redirect) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_enq && !w_deq && (r_count == c_LAST)) w_state_nxt = S_FULL;
                S_FULL:  if (w_deq) w_state_nxt = S_RUN;
                default: w_state_nxt = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_RUN;
            r_fetch_pc <= PC_INIT;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_enq) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tail     <= r_tail + c_PTR_W'(1);
                end
                if (w_deq) begin
                    r_head <= r_head + c_PTR_W'(1);
                end
                if (w_enq && !w_deq) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (w_deq && !w_enq) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // Entry storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_mem_pc[r_tail]    <= r_fetch_pc;
            r_mem_instr[r_tail] <= imemload;
        end
    end

    // Full state must agree with the occupancy counter.
    assert property (@(posedge CLK) disable iff (RST)
        (r_state == S_FULL) |-> (r_count == c_FULL));

endmodule
`default_nettype wire
